// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register index, hazard FSM state and
// the saved write-back bundle handed to the forwarding unit.
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IND1 = 2'd1,
    S_IND2 = 2'd2
  } lc3b_hazard_state;

  typedef struct packed {
    logic    load_regfile_wb;
    lc3b_reg dest_wb;
  } lc3b_forward_save;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an ID source that depends on the
// destination of a load still sitting in EX.
module load_use_detect
  import lc3b_types::*;
(
  input  logic    ex_is_load,
  input  logic    ex_load_regfile,
  input  lc3b_reg ex_dest,
  input  lc3b_reg id_src1,
  input  lc3b_reg id_src2,
  input  logic    id_src1_valid,
  input  logic    id_src2_valid,
  output logic    hazard
);

  logic hit1;
  logic hit2;

  assign hit1   = id_src1_valid & (id_src1 == ex_dest);
  assign hit2   = id_src2_valid & (id_src2 == ex_dest);
  assign hazard = ex_is_load & ex_load_regfile & (hit1 | hit2);

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall control: indirect-memory FSM, load-use bubble
// counter and the WB snapshot kept alive across back-end freezes.
module hazard_stall_unit
  import lc3b_types::*;
#(
  parameter int LOAD_USE_STALL = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  lc3b_reg          id_src1,
  input  lc3b_reg          id_src2,
  input  logic             id_src1_valid,
  input  logic             id_src2_valid,
  input  logic             ex_is_load,
  input  logic             ex_load_regfile,
  input  lc3b_reg          ex_dest,
  input  logic             mem_access,
  input  logic             mem_indirect,
  input  logic             mem_resp,
  input  logic             wb_load_regfile,
  input  lc3b_reg          wb_dest,
  output logic             stall_front,
  output logic             stall_back,
  output logic             bubble_ex,
  output logic             indirectmux_sel,
  output lc3b_forward_save forward_save
);

  localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALL - 1);

  lc3b_hazard_state state;
  lc3b_hazard_state state_next;
  logic             hazard;
  logic             back_raw;
  logic [1:0]       cnt;
  logic             cnt_busy;
  logic             stall_q;
  logic             stall_rise;
  lc3b_forward_save save_q;
  lc3b_forward_save wb_now;

  load_use_detect u_detect (
    .ex_is_load      (ex_is_load),
    .ex_load_regfile (ex_load_regfile),
    .ex_dest         (ex_dest),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_src1_valid   (id_src1_valid),
    .id_src2_valid   (id_src2_valid),
    .hazard          (hazard)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:
        if (mem_access & mem_indirect)
          state_next = mem_resp ? S_IND2 : S_IND1;
      S_IND1:
        if (mem_resp) state_next = S_IND2;
      S_IND2:
        if (mem_resp) state_next = S_IDLE;
      default:
        state_next = S_IDLE;
    endcase
  end

  // Entering an indirect op freezes the back end even if the
  // pointer read completes at once: the data access still follows.
  always_comb begin
    back_raw        = 1'b0;
    indirectmux_sel = 1'b0;
    unique case (state)
      S_IDLE: back_raw = mem_access & (~mem_resp | mem_indirect);
      S_IND1: back_raw = 1'b1;
      S_IND2: begin
        back_raw        = mem_access & ~mem_resp;
        indirectmux_sel = 1'b1;
      end
      default: back_raw = 1'b0;
    endcase
  end

  assign cnt_busy    = (cnt != 2'd0);
  assign stall_back  = reset_n & back_raw;
  assign stall_front = reset_n & (back_raw | hazard | cnt_busy);
  assign bubble_ex   = reset_n & ~back_raw & (hazard | cnt_busy);

  // Bubble counter only moves while the back end is advancing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 2'd0;
    end else if (!stall_back) begin
      if (cnt_busy)    cnt <= cnt - 2'd1;
      else if (hazard) cnt <= STALL_INIT;
    end
  end

  assign wb_now     = {wb_load_regfile, wb_dest};
  assign stall_rise = stall_back & ~stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= 1'b0;
      save_q  <= '0;
    end else begin
      stall_q <= stall_back;
      if (stall_rise)      save_q <= wb_now;
      else if (!stall_back) save_q <= '0;
    end
  end

  assign forward_save = stall_rise ? wb_now : save_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: one instance per bubble
// depth (1 and 2) driven from shared stimulus.
module tb_hazard_stall_unit;
  import lc3b_types::*;

  logic    clk;
  logic    reset_n;
  lc3b_reg id_src1, id_src2, ex_dest, wb_dest;
  logic    id_src1_valid, id_src2_valid;
  logic    ex_is_load, ex_load_regfile;
  logic    mem_access, mem_indirect, mem_resp;
  logic    wb_load_regfile;

  logic sf1, sb1, bub1, sel1;
  logic sf2, sb2, bub2, sel2;
  lc3b_forward_save fs1, fs2;
  logic [7:0] got1, got2;

  int n_cmp  = 0;
  int n_fail = 0;

  hazard_stall_unit #(.LOAD_USE_STALL(1)) u1 (
    .clk(clk), .reset_n(reset_n),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_valid(id_src1_valid), .id_src2_valid(id_src2_valid),
    .ex_is_load(ex_is_load), .ex_load_regfile(ex_load_regfile),
    .ex_dest(ex_dest),
    .mem_access(mem_access), .mem_indirect(mem_indirect),
    .mem_resp(mem_resp),
    .wb_load_regfile(wb_load_regfile), .wb_dest(wb_dest),
    .stall_front(sf1), .stall_back(sb1), .bubble_ex(bub1),
    .indirectmux_sel(sel1), .forward_save(fs1)
  );

  hazard_stall_unit #(.LOAD_USE_STALL(2)) u2 (
    .clk(clk), .reset_n(reset_n),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_valid(id_src1_valid), .id_src2_valid(id_src2_valid),
    .ex_is_load(ex_is_load), .ex_load_regfile(ex_load_regfile),
    .ex_dest(ex_dest),
    .mem_access(mem_access), .mem_indirect(mem_indirect),
    .mem_resp(mem_resp),
    .wb_load_regfile(wb_load_regfile), .wb_dest(wb_dest),
    .stall_front(sf2), .stall_back(sb2), .bubble_ex(bub2),
    .indirectmux_sel(sel2), .forward_save(fs2)
  );

  assign got1 = {sf1, sb1, bub1, sel1, fs1};
  assign got2 = {sf2, sb2, bub2, sel2, fs2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] s1;
    logic [2:0] s2;
    logic       v1;
    logic       v2;
    logic       ld;
    logic       wr;
    logic [2:0] dst;
    logic       acc;
    logic       ind;
    logic       rsp;
    logic       wbw;
    logic [2:0] wbd;
    logic [7:0] exp;
  } vec_t;

  function automatic logic [7:0] e(input logic sf, input logic sb,
                                   input logic bub, input logic sel,
                                   input logic [3:0] fs);
    return {sf, sb, bub, sel, fs};
  endfunction

  task automatic chk(input string n, input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {sf,sb,bub,sel,fs}=%b required %b",
               n, got, exp);
    end
  endtask

  task automatic clr_in();
    id_src1 = 3'd0; id_src2 = 3'd0;
    id_src1_valid = 1'b0; id_src2_valid = 1'b0;
    ex_is_load = 1'b0; ex_load_regfile = 1'b0; ex_dest = 3'd0;
    mem_access = 1'b0; mem_indirect = 1'b0; mem_resp = 1'b0;
    wb_load_regfile = 1'b0; wb_dest = 3'd0;
  endtask

  task automatic haz_in(input logic on);
    id_src1 = 3'd1; id_src1_valid = on;
    ex_is_load = on; ex_load_regfile = on; ex_dest = 3'd1;
  endtask

  task automatic mem_in(input logic acc, input logic ind,
                        input logic rsp);
    mem_access = acc; mem_indirect = ind; mem_resp = rsp;
  endtask

  task automatic cyc(input string n, input logic [7:0] x1,
                     input logic [7:0] x2);
    @(negedge clk);
    chk({n, "/lus1"}, got1, x1);
    chk({n, "/lus2"}, got2, x2);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{0,0,0,0,0,0,0, 0,0,0, 0,0, e(0,0,0,0,4'h0)};
    tbl[1]  = '{1,0,1,0,1,1,1, 0,0,0, 0,0, e(1,0,1,0,4'h0)};
    tbl[2]  = '{0,5,0,1,1,1,5, 0,0,0, 0,0, e(1,0,1,0,4'h0)};
    tbl[3]  = '{3,5,1,0,1,1,5, 0,0,0, 0,0, e(0,0,0,0,4'h0)};
    tbl[4]  = '{2,0,1,0,1,0,2, 0,0,0, 0,0, e(0,0,0,0,4'h0)};
    tbl[5]  = '{2,0,1,0,0,1,2, 0,0,0, 0,0, e(0,0,0,0,4'h0)};
    tbl[6]  = '{4,6,0,1,1,1,4, 0,0,0, 0,0, e(0,0,0,0,4'h0)};
    tbl[7]  = '{0,0,0,0,0,0,0, 0,1,0, 0,0, e(0,0,0,0,4'h0)};
    tbl[8]  = '{0,0,0,0,0,0,0, 1,0,0, 1,6, e(1,1,0,0,4'hE)};
    tbl[9]  = '{1,0,1,0,1,1,1, 1,0,0, 0,2, e(1,1,0,0,4'hE)};
    tbl[10] = '{1,0,1,0,1,1,1, 1,0,1, 0,2, e(1,0,1,0,4'hE)};
    tbl[11] = '{0,0,0,0,0,0,0, 0,0,0, 0,0, e(0,0,0,0,4'h0)};

    // Reset asserted with hostile inputs: outputs must be forced low.
    reset_n = 1'b0;
    clr_in();
    haz_in(1'b1);
    mem_in(1'b1, 1'b1, 1'b0);
    wb_load_regfile = 1'b1; wb_dest = 3'd5;
    #2;
    chk("reset_async/lus1", got1, e(0,0,0,0,4'h0));
    chk("reset_async/lus2", got2, e(0,0,0,0,4'h0));
    clr_in();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      id_src1 = tbl[i].s1; id_src2 = tbl[i].s2;
      id_src1_valid = tbl[i].v1; id_src2_valid = tbl[i].v2;
      ex_is_load = tbl[i].ld; ex_load_regfile = tbl[i].wr;
      ex_dest = tbl[i].dst;
      mem_in(tbl[i].acc, tbl[i].ind, tbl[i].rsp);
      wb_load_regfile = tbl[i].wbw; wb_dest = tbl[i].wbd;
      @(negedge clk);
      chk($sformatf("table[%0d]", i), got1, tbl[i].exp);
      @(posedge clk);
      #1;
    end
    clr_in();
    cyc("table_drain", e(0,0,0,0,4'h0), e(0,0,0,0,4'h0));

    // LDI with responses in cycles 3 and 6, WB writing R4 at entry.
    mem_in(1'b1, 1'b1, 1'b0);
    wb_load_regfile = 1'b1; wb_dest = 3'd4;
    cyc("ldi_c0", e(1,1,0,0,4'hC), e(1,1,0,0,4'hC));
    wb_load_regfile = 1'b0; wb_dest = 3'd7;
    cyc("ldi_c1", e(1,1,0,0,4'hC), e(1,1,0,0,4'hC));
    cyc("ldi_c2", e(1,1,0,0,4'hC), e(1,1,0,0,4'hC));
    mem_resp = 1'b1;
    cyc("ldi_c3", e(1,1,0,0,4'hC), e(1,1,0,0,4'hC));
    mem_resp = 1'b0;
    cyc("ldi_c4", e(1,1,0,1,4'hC), e(1,1,0,1,4'hC));
    cyc("ldi_c5", e(1,1,0,1,4'hC), e(1,1,0,1,4'hC));
    mem_resp = 1'b1;
    cyc("ldi_c6", e(0,0,0,1,4'hC), e(0,0,0,1,4'hC));
    clr_in();
    cyc("ldi_c7", e(0,0,0,0,4'h0), e(0,0,0,0,4'h0));

    // Immediate pointer response, then back-to-back indirect ops.
    mem_in(1'b1, 1'b1, 1'b1);
    cyc("b2b_c0", e(1,1,0,0,4'h0), e(1,1,0,0,4'h0));
    mem_resp = 1'b0;
    cyc("b2b_c1", e(1,1,0,1,4'h0), e(1,1,0,1,4'h0));
    mem_resp = 1'b1;
    cyc("b2b_c2", e(0,0,0,1,4'h0), e(0,0,0,1,4'h0));
    mem_resp = 1'b0;
    cyc("b2b_c3", e(1,1,0,0,4'h0), e(1,1,0,0,4'h0));
    mem_resp = 1'b1;
    cyc("b2b_c4", e(1,1,0,0,4'h0), e(1,1,0,0,4'h0));
    cyc("b2b_c5", e(0,0,0,1,4'h0), e(0,0,0,1,4'h0));
    clr_in();
    cyc("b2b_c6", e(0,0,0,0,4'h0), e(0,0,0,0,4'h0));

    // Plain load-use: one bubble at depth 1, two at depth 2.
    haz_in(1'b1);
    cyc("lu_c0", e(1,0,1,0,4'h0), e(1,0,1,0,4'h0));
    ex_is_load = 1'b0; ex_load_regfile = 1'b0;
    cyc("lu_c1", e(0,0,0,0,4'h0), e(1,0,1,0,4'h0));
    cyc("lu_c2", e(0,0,0,0,4'h0), e(0,0,0,0,4'h0));
    clr_in();

    // Load-use arriving during a MEM freeze.
    haz_in(1'b1);
    mem_in(1'b1, 1'b0, 1'b0);
    cyc("frz_c0", e(1,1,0,0,4'h0), e(1,1,0,0,4'h0));
    cyc("frz_c1", e(1,1,0,0,4'h0), e(1,1,0,0,4'h0));
    mem_resp = 1'b1;
    cyc("frz_c2", e(1,0,1,0,4'h0), e(1,0,1,0,4'h0));
    mem_in(1'b0, 1'b0, 1'b0);
    ex_is_load = 1'b0; ex_load_regfile = 1'b0;
    cyc("frz_c3", e(0,0,0,0,4'h0), e(1,0,1,0,4'h0));
    cyc("frz_c4", e(0,0,0,0,4'h0), e(0,0,0,0,4'h0));
    clr_in();

    // Freeze arriving while bubbles are pending: counter holds.
    haz_in(1'b1);
    cyc("hold_c0", e(1,0,1,0,4'h0), e(1,0,1,0,4'h0));
    ex_is_load = 1'b0; ex_load_regfile = 1'b0;
    mem_in(1'b1, 1'b0, 1'b0);
    cyc("hold_c1", e(1,1,0,0,4'h0), e(1,1,0,0,4'h0));
    cyc("hold_c2", e(1,1,0,0,4'h0), e(1,1,0,0,4'h0));
    mem_in(1'b0, 1'b0, 1'b0);
    cyc("hold_c3", e(0,0,0,0,4'h0), e(1,0,1,0,4'h0));
    cyc("hold_c4", e(0,0,0,0,4'h0), e(0,0,0,0,4'h0));
    clr_in();

    // Reset while in the data phase of an indirect op.
    mem_in(1'b1, 1'b1, 1'b0);
    cyc("rst_c0", e(1,1,0,0,4'h0), e(1,1,0,0,4'h0));
    mem_resp = 1'b1;
    cyc("rst_c1", e(1,1,0,0,4'h0), e(1,1,0,0,4'h0));
    mem_resp = 1'b0;
    @(negedge clk);
    chk("rst_ind2/lus1", got1, e(1,1,0,1,4'h0));
    chk("rst_ind2/lus2", got2, e(1,1,0,1,4'h0));
    reset_n = 1'b0;
    haz_in(1'b1);
    wb_load_regfile = 1'b1; wb_dest = 3'd3;
    #1;
    chk("rst_mid/lus1", got1, e(0,0,0,0,4'h0));
    chk("rst_mid/lus2", got2, e(0,0,0,0,4'h0));
    @(posedge clk);
    #1;
    chk("rst_hold/lus1", got1, e(0,0,0,0,4'h0));
    chk("rst_hold/lus2", got2, e(0,0,0,0,4'h0));
    clr_in();
    reset_n = 1'b1;
    cyc("rst_post", e(0,0,0,0,4'h0), e(0,0,0,0,4'h0));
    mem_in(1'b1, 1'b1, 1'b0);
    cyc("rst_re_c0", e(1,1,0,0,4'h0), e(1,1,0,0,4'h0));
    mem_resp = 1'b1;
    cyc("rst_re_c1", e(1,1,0,0,4'h0), e(1,1,0,0,4'h0));
    cyc("rst_re_c2", e(0,0,0,1,4'h0), e(0,0,0,1,4'h0));
    clr_in();
    cyc("rst_re_c3", e(0,0,0,0,4'h0), e(0,0,0,0,4'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
